// File: rtl/team_06_pwm_out.sv
// team_06 audio output stage: small sample FIFO feeding an 8-bit PWM generator.
// One sample is consumed per 256-cycle period; underrun flags an empty FIFO at a period boundary.
module team_06_pwm_out #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  IDLE_DUTY = 8'h80
) (
  input  logic                     clkdiv,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     pwm_out,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C = CW'(0);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  typedef enum logic {
    ST_DISABLED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic [7:0]    cnt_r;
  logic [7:0]    duty_r;
  logic          pwm_r;
  logic          underrun_r;

  state_t        state_s;
  logic          push_s;
  logic          pop_s;
  logic [7:0]    cnt_nxt_s;
  logic [7:0]    duty_nxt_s;
  logic          pwm_nxt_s;
  logic          underrun_nxt_s;
  logic [CW-1:0] count_nxt_s;

  assign sample_ready = (count_r != FULL_C);
  assign push_s       = sample_valid && sample_ready;
  assign pwm_out      = pwm_r;
  assign underrun     = underrun_r;
  assign fifo_count   = count_r;

  // PWM mode, counter/output next values and boundary pop/underrun decision
  always_comb begin
    state_s        = ST_DISABLED;
    cnt_nxt_s      = cnt_r;
    pwm_nxt_s      = 1'b0;
    underrun_nxt_s = 1'b0;
    pop_s          = 1'b0;
    if (en) begin
      state_s = ST_RUN;
    end else begin
      state_s = ST_DISABLED;
    end
    case (state_s)
      ST_RUN: begin
        pwm_nxt_s = (cnt_r < duty_r);
        cnt_nxt_s = cnt_r + 8'd1;
        if (cnt_r == 8'hFF) begin
          // pop decision uses occupancy before any same-cycle push
          if (count_r != CNT_ZERO_C) begin
            pop_s = 1'b1;
          end else begin
            underrun_nxt_s = 1'b1;
          end
        end else begin
          pop_s          = 1'b0;
          underrun_nxt_s = 1'b0;
        end
      end
      ST_DISABLED: begin
        cnt_nxt_s = 8'd0;
        pwm_nxt_s = 1'b0;
      end
      default: begin
        cnt_nxt_s = 8'd0;
        pwm_nxt_s = 1'b0;
      end
    endcase
  end

  // Duty reload and FIFO occupancy next values
  always_comb begin
    duty_nxt_s  = duty_r;
    count_nxt_s = count_r;
    if (pop_s) begin
      duty_nxt_s = mem_r[rptr_r];
    end else begin
      duty_nxt_s = duty_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE_C;
      2'b01:   count_nxt_s = count_r - CNT_ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO sample storage
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_r[wptr_r] <= sample_in;
    end
  end

  // Pointers, occupancy, PWM counter, duty and registered outputs
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      wptr_r     <= {AW{1'b0}};
      rptr_r     <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      cnt_r      <= 8'd0;
      duty_r     <= IDLE_DUTY;
      pwm_r      <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE_C;
      end
      count_r    <= count_nxt_s;
      cnt_r      <= cnt_nxt_s;
      duty_r     <= duty_nxt_s;
      pwm_r      <= pwm_nxt_s;
      underrun_r <= underrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_team_06_pwm_out.sv
// Scoreboard bench for team_06_pwm_out: a period-level reference model queues expected
// high counts and underrun flags; a monitor measures each completed PWM period and compares.
module tb_team_06_pwm_out;

  localparam int DEPTH = 4;
  localparam int IDLE  = 8'h80;

  logic       clkdiv = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       pwm_out;
  logic       underrun;
  logic [2:0] fifo_count;

  team_06_pwm_out #(.DEPTH(DEPTH), .IDLE_DUTY(8'h80)) dut (
    .clkdiv(clkdiv), .rst(rst), .en(en), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .pwm_out(pwm_out), .underrun(underrun), .fifo_count(fifo_count)
  );

  always #5 clkdiv = ~clkdiv;

  typedef struct {
    int duty;
    int und;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];
  int   mduty = IDLE;
  int   phase = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic run_edge = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock edge, tracking where in the 256-cycle period we are.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic e);
    bit accepted;
    exp_t x;
    accepted = v && (mq.size() < DEPTH);
    if (e) begin
      if (phase == 255) begin
        x.duty = mduty;
        x.und  = (mq.size() == 0) ? 1 : 0;
        exp_q.push_back(x);
        if (mq.size() > 0) mduty = mq.pop_front();
        phase = 0;
      end else begin
        phase++;
      end
    end else begin
      phase = 0;
    end
    if (accepted) mq.push_back(int'(d));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic e);
    sample_valid = v;
    sample_in    = d;
    en           = e;
    @(posedge clkdiv);
    model_edge(v, d, e);
    #2;
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("sample_ready", int'(sample_ready), (mq.size() < DEPTH) ? 1 : 0);
    if (!e) chk("pwm_low_when_disabled", int'(pwm_out), 0);
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, e);
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < 300 && phase != p; i++) step(1'b0, 8'h00, 1'b1);
    chk("reached_phase", phase, p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_sample_ready", int'(sample_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    mq.delete();
    mduty = IDLE;
    phase = 0;
    @(posedge clkdiv);
    #2;
    rst = 1'b0;
  endtask

  always @(posedge clkdiv) run_edge = en && !rst;

  // Monitor: measure high cycles over each completed period and pop the scoreboard.
  initial begin
    int acc;
    int hi;
    exp_t x;
    acc = 0;
    hi  = 0;
    forever begin
      @(negedge clkdiv);
      if (rst || !run_edge) begin
        acc = 0;
        hi  = 0;
        chk("underrun_idle", int'(underrun), 0);
      end else begin
        acc++;
        hi += int'(pwm_out);
        if (acc == 256) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
          end else begin
            x = exp_q.pop_front();
            chk("period_high_count", hi, x.duty);
            chk("underrun_at_boundary", int'(underrun), x.und);
          end
          acc = 0;
          hi  = 0;
        end else begin
          chk("underrun_idle", int'(underrun), 0);
        end
      end
    end
  end

  initial begin
    logic e;
    int   dmin;
    #2;
    do_reset();

    // reset mid-run with three samples queued
    run(20, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    run(30, 1'b1);
    chk("three_queued", int'(fifo_count), 3);
    do_reset();
    run(520, 1'b1);

    // duty extremes
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h40, 1'b1);
    run(256 * 5, 1'b1);

    // backpressure with PWM disabled: fifth sample dropped
    run(3, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b1, 8'(k), 1'b0);
    chk("full_count", int'(fifo_count), 4);
    chk("full_ready_low", int'(sample_ready), 0);
    run(256 * 6, 1'b1);

    // simultaneous push and boundary with empty FIFO
    run_to_phase(255);
    step(1'b1, 8'h20, 1'b1);
    chk("simul_count", int'(fifo_count), 1);
    run(600, 1'b1);

    // enable toggle mid-period with duty 0xC0
    step(1'b1, 8'hC0, 1'b1);
    for (int i = 0; i < 1100 && mduty != 8'hC0; i++) step(1'b0, 8'h00, 1'b1);
    chk("duty_c0_loaded", mduty, 8'hC0);
    run_to_phase(100);
    step(1'b1, 8'h11, 1'b0);
    run(15, 1'b0);
    run(600, 1'b1);

    // randomized traffic and enable toggling
    e = 1'b1;
    for (int s = 0; s < 6; s++) begin
      dmin = (s % 2 == 0) ? 100 : 400;
      for (int i = 0; i < 700; i++) begin
        if ($urandom_range(0, 599) == 0) e = ~e;
        step($urandom_range(0, dmin) == 0, 8'($urandom_range(0, 255)), e);
      end
    end
    run(300, 1'b1);

    @(negedge clkdiv);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
